// File: rtl/noc_cfg_pkg.sv
// Shared opcodes, FSM state encoding and width helpers for the NoC serial
// configuration loader.
package noc_cfg_pkg;

    localparam logic [1:0] OPC_WRITE = 2'b00;
    localparam logic [1:0] OPC_READ  = 2'b01;
    localparam logic [1:0] OPC_START = 2'b10;
    localparam logic [1:0] OPC_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_WRITE,
        ST_START,
        ST_READ,
        ST_DRAIN,
        ST_COMMIT
    } state_t;

    // Per-node config word: {dst_seq, send_flag, recv_flag}.
    function automatic int cfg_w(input int seq_w, input int flag_w);
        return seq_w + 2 * flag_w;
    endfunction

    // Counter wide enough to reach n+1 so an overlong frame stays distinguishable.
    function automatic int cnt_w(input int n);
        return $clog2(n + 2);
    endfunction

endpackage

// File: rtl/noc_done_latch.sv
// Bank of sticky event latches: set by a per-node event, cleared by a
// snapshot; a set coinciding with the snapshot wins and is also reported.
module noc_done_latch #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_set,
    input  logic         i_clr,
    output logic [N-1:0] o_snap
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= i_set | (r_q & {N{~i_clr}});
        end
    end

    assign o_snap = r_q | i_set;

endmodule

// File: rtl/noc_cfg_loader.sv
// Framed 3-wire serial configuration/status controller: shifts in per-node
// NoC config words and start masks, and reads back latched task-done events.
module noc_cfg_loader
    import noc_cfg_pkg::*;
#(
    parameter int NODES  = 4,
    parameter int SEQ_W  = 6,
    parameter int FLAG_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_frame,
    input  logic                    cfg_bit_vld,
    input  logic                    cfg_sdi,
    output logic                    cfg_sdo,
    output logic                    cfg_sdo_vld,
    output logic                    cfg_busy,
    output logic                    cfg_err,
    output logic                    cfg_update,
    output logic [NODES*SEQ_W-1:0]  node_dst_seq,
    output logic [NODES*FLAG_W-1:0] node_send_flag,
    output logic [NODES*FLAG_W-1:0] node_recv_flag,
    output logic [NODES-1:0]        node_start,
    input  logic [NODES-1:0]        node_send_done,
    input  logic [NODES-1:0]        node_recv_done
);

    localparam int CFG_W = cfg_w(SEQ_W, FLAG_W);
    localparam int PAY_W = NODES * CFG_W;
    localparam int RD_W  = 2 * NODES;
    localparam int CNT_W = cnt_w(PAY_W);

    localparam logic [CNT_W-1:0] CNT_PAY   = CNT_W'(PAY_W);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(PAY_W + 1);
    localparam logic [CNT_W-1:0] CNT_NODES = CNT_W'(NODES);
    localparam logic [CNT_W-1:0] CNT_RD    = CNT_W'(RD_W);

    state_t                    r_state;
    logic                      r_armed;
    logic                      r_opc_cnt;
    logic                      r_opc_msb;
    logic [CNT_W-1:0]          r_cnt;
    logic [PAY_W-1:0]          r_shift;
    logic [NODES-1:0]          r_mask;
    logic [RD_W-1:0]           r_rd_shift;
    logic                      r_sdo;
    logic                      r_sdo_vld;
    logic                      r_err;
    logic                      r_update;
    logic [NODES-1:0]          r_start;
    logic [NODES*SEQ_W-1:0]    r_dst_seq;
    logic [NODES*FLAG_W-1:0]   r_send_flag;
    logic [NODES*FLAG_W-1:0]   r_recv_flag;

    state_t                    w_state_nxt;
    logic                      w_bit;
    logic                      w_set_err;
    logic                      w_clr_err;
    logic                      w_commit;
    logic                      w_fire;
    logic                      w_snapshot;
    logic [NODES-1:0]          w_send_snap;
    logic [NODES-1:0]          w_recv_snap;

    assign w_bit = cfg_frame & cfg_bit_vld;

    noc_done_latch #(.N(NODES)) u_send_latch (
        .clk    (clk),
        .rst    (rst),
        .i_set  (node_send_done),
        .i_clr  (w_snapshot),
        .o_snap (w_send_snap)
    );

    noc_done_latch #(.N(NODES)) u_recv_latch (
        .clk    (clk),
        .rst    (rst),
        .i_set  (node_recv_done),
        .i_clr  (w_snapshot),
        .o_snap (w_recv_snap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        w_clr_err   = 1'b0;
        w_commit    = 1'b0;
        w_fire      = 1'b0;
        w_snapshot  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cfg_frame && r_armed) begin
                    w_state_nxt = ST_OPC;
                    w_clr_err   = 1'b1;
                end
            end
            ST_OPC: begin
                if (!cfg_frame) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_bit && r_opc_cnt) begin
                    case ({r_opc_msb, cfg_sdi})
                        OPC_WRITE: w_state_nxt = ST_WRITE;
                        OPC_START: w_state_nxt = ST_START;
                        OPC_READ: begin
                            w_state_nxt = ST_READ;
                            w_snapshot  = 1'b1;
                        end
                        OPC_RSVD: begin
                            w_set_err   = 1'b1;
                            w_state_nxt = ST_DRAIN;
                        end
                    endcase
                end
            end
            ST_WRITE: begin
                if (!cfg_frame) begin
                    if (r_cnt == CNT_PAY) begin
                        w_state_nxt = ST_COMMIT;
                        w_commit    = 1'b1;
                    end else begin
                        w_set_err   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_COMMIT: begin
                w_set_err   = w_bit;
                w_state_nxt = ST_IDLE;
            end
            ST_START: begin
                if (!cfg_frame) begin
                    w_state_nxt = ST_IDLE;
                    if (r_cnt == CNT_NODES) begin
                        w_fire = 1'b1;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            ST_READ, ST_DRAIN: begin
                if (!cfg_frame) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_armed     <= 1'b0;
            r_opc_cnt   <= 1'b0;
            r_opc_msb   <= 1'b0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_mask      <= '0;
            r_rd_shift  <= '0;
            r_sdo       <= 1'b0;
            r_sdo_vld   <= 1'b0;
            r_err       <= 1'b0;
            r_update    <= 1'b0;
            r_start     <= '0;
            r_dst_seq   <= '0;
            r_send_flag <= '0;
            r_recv_flag <= '0;
        end else begin
            r_armed   <= r_armed | ~cfg_frame;
            r_update  <= w_commit;
            r_start   <= w_fire ? r_mask : '0;
            r_sdo     <= 1'b0;
            r_sdo_vld <= 1'b0;

            if (w_clr_err) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end

            // Outputs load on the edge entering COMMIT so they coincide with cfg_update.
            if (w_commit) begin
                for (int i = 0; i < NODES; i++) begin
                    r_dst_seq[i*SEQ_W +: SEQ_W]    <= r_shift[i*CFG_W + 2*FLAG_W +: SEQ_W];
                    r_send_flag[i*FLAG_W +: FLAG_W] <= r_shift[i*CFG_W + FLAG_W +: FLAG_W];
                    r_recv_flag[i*FLAG_W +: FLAG_W] <= r_shift[i*CFG_W +: FLAG_W];
                end
            end

            if (w_snapshot) begin
                r_rd_shift <= {w_send_snap, w_recv_snap};
            end

            case (r_state)
                ST_IDLE: r_opc_cnt <= 1'b0;
                ST_OPC: begin
                    r_cnt <= '0;
                    if (w_bit) begin
                        r_opc_msb <= cfg_sdi;
                        r_opc_cnt <= 1'b1;
                    end
                end
                ST_WRITE, ST_START, ST_READ: begin
                    if (w_bit) begin
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                        if (r_state == ST_WRITE) begin
                            r_shift <= PAY_W'({r_shift, cfg_sdi});
                        end
                        if (r_state == ST_START) begin
                            r_mask <= NODES'({r_mask, cfg_sdi});
                        end
                        if (r_state == ST_READ && r_cnt < CNT_RD) begin
                            r_sdo      <= r_rd_shift[RD_W-1];
                            r_sdo_vld  <= 1'b1;
                            r_rd_shift <= RD_W'({r_rd_shift, 1'b0});
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cfg_busy       = (r_state != ST_IDLE);
    assign cfg_err        = r_err;
    assign cfg_update     = r_update;
    assign cfg_sdo        = r_sdo;
    assign cfg_sdo_vld    = r_sdo_vld;
    assign node_start     = r_start;
    assign node_dst_seq   = r_dst_seq;
    assign node_send_flag = r_send_flag;
    assign node_recv_flag = r_recv_flag;

endmodule

// File: tb/tb_noc_cfg_loader.sv
// Scoreboard bench for noc_cfg_loader: stimulus pushes expected events, a
// negedge monitor pops and compares whenever the DUT emits one.
module tb_noc_cfg_loader;

    localparam int NODES  = 4;
    localparam int SEQ_W  = 6;
    localparam int FLAG_W = 2;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    cfg_frame = 1'b0;
    logic                    cfg_bit_vld = 1'b0;
    logic                    cfg_sdi = 1'b0;
    logic                    cfg_sdo;
    logic                    cfg_sdo_vld;
    logic                    cfg_busy;
    logic                    cfg_err;
    logic                    cfg_update;
    logic [NODES*SEQ_W-1:0]  node_dst_seq;
    logic [NODES*FLAG_W-1:0] node_send_flag;
    logic [NODES*FLAG_W-1:0] node_recv_flag;
    logic [NODES-1:0]        node_start;
    logic [NODES-1:0]        node_send_done = '0;
    logic [NODES-1:0]        node_recv_done = '0;

    noc_cfg_loader #(.NODES(NODES), .SEQ_W(SEQ_W), .FLAG_W(FLAG_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_frame      (cfg_frame),
        .cfg_bit_vld    (cfg_bit_vld),
        .cfg_sdi        (cfg_sdi),
        .cfg_sdo        (cfg_sdo),
        .cfg_sdo_vld    (cfg_sdo_vld),
        .cfg_busy       (cfg_busy),
        .cfg_err        (cfg_err),
        .cfg_update     (cfg_update),
        .node_dst_seq   (node_dst_seq),
        .node_send_flag (node_send_flag),
        .node_recv_flag (node_recv_flag),
        .node_start     (node_start),
        .node_send_done (node_send_done),
        .node_recv_done (node_recv_done)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_UPD, EV_START, EV_SDO} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [63:0] data;
    } ev_t;

    ev_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    // Expected config values for the two good writes: {dst_seq, send, recv}.
    localparam logic [39:0] EXP1 = {24'hA80000, 8'h80, 8'h40};
    localparam logic [39:0] EXP2 = {6'h20, 6'h01, 6'h3F, 6'h15,
                                    2'b10, 2'b01, 2'b00, 2'b11,
                                    2'b01, 2'b00, 2'b11, 2'b10};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input ev_kind_t kind, input logic [63:0] data);
        ev_t e;
        e.kind = kind;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic push_sdo(input logic [15:0] bits, input int n);
        logic [15:0] v;
        v = bits;
        for (int i = n - 1; i >= 0; i--) push(EV_SDO, 64'(v[i]));
    endtask

    task automatic observe(input ev_kind_t kind, input logic [63:0] data);
        ev_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected event kind=%0d actual=%0h required=none at %0t", kind, data, $time);
        end else begin
            e = sb_q.pop_front();
            check("event kind", 64'(kind), 64'(e.kind));
            check("event data", data, e.data);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cfg_update) observe(EV_UPD, 64'({node_dst_seq, node_send_flag, node_recv_flag}));
                if (node_start != '0) observe(EV_START, 64'(node_start));
                if (cfg_sdo_vld) observe(EV_SDO, 64'(cfg_sdo));
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic frame_begin();
        @(negedge clk);
        cfg_frame   = 1'b1;
        cfg_bit_vld = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        cfg_bit_vld = 1'b1;
        cfg_sdi     = b;
    endtask

    task automatic frame_end();
        @(negedge clk);
        cfg_bit_vld = 1'b0;
        cfg_sdi     = 1'b0;
        cfg_frame   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic write_frame(input logic [63:0] payload, input int nbits);
        frame_begin();
        send_bits(64'b00, 2);
        send_bits(payload, nbits);
        frame_end();
    endtask

    task automatic start_frame(input logic [63:0] mask, input int nbits);
        frame_begin();
        send_bits(64'b10, 2);
        send_bits(mask, nbits);
        frame_end();
    endtask

    // inj_send is driven on node_send_done in the snapshot cycle.
    task automatic read_frame(input int nbits, input logic [NODES-1:0] inj_send);
        frame_begin();
        send_bit(1'b0);
        send_bit(1'b1);
        node_send_done = inj_send;
        for (int i = 0; i < nbits; i++) begin
            send_bit(1'b0);
            node_send_done = '0;
        end
        node_send_done = '0;
        frame_end();
    endtask

    task automatic pulse_done(input logic [NODES-1:0] s, input logic [NODES-1:0] r);
        @(negedge clk);
        node_send_done = s;
        node_recv_done = r;
        @(negedge clk);
        node_send_done = '0;
        node_recv_done = '0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        check("reset dst_seq", 64'(node_dst_seq), 64'h0);
        check("reset flags", 64'({node_send_flag, node_recv_flag}), 64'h0);
        check("reset start", 64'(node_start), 64'h0);
        check("reset busy", 64'(cfg_busy), 64'h0);
        check("reset err", 64'(cfg_err), 64'h0);

        // Good write: node3 seq=2A, send=10, recv=01.
        push(EV_UPD, 64'(EXP1));
        write_frame(64'({6'h2A, 2'b10, 2'b01, 30'b0}), 40);
        check("write1 node3 seq", 64'(node_dst_seq[23:18]), 64'h2A);
        check("write1 err", 64'(cfg_err), 64'h0);
        check("write1 idle", 64'(cfg_busy), 64'h0);

        // Short write: 39 bits leave outputs alone.
        write_frame(64'h55_5555_5555, 39);
        check("short write err", 64'(cfg_err), 64'h1);
        check("short write hold", 64'({node_dst_seq, node_send_flag, node_recv_flag}), 64'(EXP1));

        // Overlong write also fails.
        write_frame(64'h0, 41);
        check("long write err", 64'(cfg_err), 64'h1);

        // Good write with every node distinct; clears the sticky error.
        push(EV_UPD, 64'(EXP2));
        write_frame(64'({6'h20, 2'b10, 2'b01, 6'h01, 2'b01, 2'b00,
                         6'h3F, 2'b00, 2'b11, 6'h15, 2'b11, 2'b10}), 40);
        check("write2 err cleared", 64'(cfg_err), 64'h0);

        // Start pulse.
        push(EV_START, 64'h5);
        start_frame(64'b0101, 4);
        check("start after pulse", 64'(node_start), 64'h0);
        check("start err", 64'(cfg_err), 64'h0);

        // Start with wrong bit count.
        start_frame(64'b111, 3);
        check("short start err", 64'(cfg_err), 64'h1);

        // Readback of latched events, then an empty re-read with extra bits.
        pulse_done(4'b0100, 4'b0001);
        push_sdo(16'b0100_0001, 8);
        read_frame(8, '0);
        check("read err cleared", 64'(cfg_err), 64'h0);
        push_sdo(16'b0000_0000, 8);
        read_frame(10, '0);

        // Event coincident with snapshot: reported now and on the next read.
        push_sdo(16'b001, 3);
        read_frame(3, 4'b0010);
        push_sdo(16'b0010_0000, 8);
        read_frame(8, '0);

        // Reserved opcode drains the frame.
        frame_begin();
        send_bits(64'b11, 2);
        send_bits(64'hABCDE, 20);
        @(negedge clk);
        check("rsvd busy in drain", 64'(cfg_busy), 64'h1);
        frame_end();
        check("rsvd err", 64'(cfg_err), 64'h1);
        check("rsvd idle", 64'(cfg_busy), 64'h0);
        check("rsvd hold", 64'({node_dst_seq, node_send_flag, node_recv_flag}), 64'(EXP2));

        // Frame dropped after one opcode bit.
        frame_begin();
        send_bit(1'b0);
        frame_end();
        check("opc abort err", 64'(cfg_err), 64'h1);

        // Reset in the middle of a write; bits after reset ignored until frame low.
        frame_begin();
        send_bits(64'b00, 2);
        send_bits(64'hFFFFF, 20);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("post-reset ignored", 64'(cfg_busy), 64'h0);
        check("post-reset outputs", 64'({node_dst_seq, node_send_flag, node_recv_flag}), 64'h0);
        check("post-reset err", 64'(cfg_err), 64'h0);
        frame_end();
        push(EV_START, 64'h8);
        start_frame(64'b1000, 4);

        repeat (5) @(negedge clk);
        check("scoreboard drained", 64'(sb_q.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
